// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types and defaults.
// Imported by the fetch FIFO and the fetch unit top.
package riscv_fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned IMEM_BYTES_DEFAULT = 4096;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO between fetch and decode.
// Flush wins over push/pop; head reads zero when empty.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  entry_t                 data_i,
  output entry_t                 head_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        mem_d[tail_q] = data_i;
        tail_d        = tail_q + 1'b1;
      end
      if (pop_i) begin
        head_d = head_q + 1'b1;
      end
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[head_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, fault detection and prefetch control.
// Feeds decode over valid/ready from the prefetch FIFO head.
module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = riscv_fetch_pkg::RESET_PC_DEFAULT,
  parameter int unsigned IMEM_BYTES = riscv_fetch_pkg::IMEM_BYTES_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = riscv_fetch_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fault_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic          fault;
  logic          pop;
  logic          push;
  logic [CW-1:0] count;
  fetch_entry_t  entry;
  fetch_entry_t  head;

  assign fault = (pc_q >= IMEM_BYTES) || (pc_q[1:0] != 2'b00);
  assign pop   = valid_o && ready_i;
  assign push  = ((count < CW'(FIFO_DEPTH)) || pop) && !redirect_i;

  always_comb begin
    entry.pc    = pc_q;
    entry.instr = fault ? NOP_INSTR : imem_rdata_i;
    entry.fault = fault;
  end

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      redirect_i: pc_d = redirect_pc_i;
      push:       pc_d = pc_q + 32'd4;
      default:    pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (entry),
    .head_o  (head),
    .valid_o (valid_o),
    .count_o (count)
  );

  assign imem_addr_o = pc_q;
  assign instr_o     = head.instr;
  assign pc_o        = head.pc;
  assign fault_o     = head.fault;

endmodule
